// File: rtl/rs_bank_pkg.sv
// Shared project defaults for the reservation-station slice: datapath widths,
// tag/ROB index widths and the register-delay hook used by sequential code.
// No ports; imported by rs_entry and rs_bank.
`ifndef RS_BANK_DEFINES
`define RS_BANK_DEFINES
`define PRN_BITS 6
`define ROB_BITS 5
// Register-delay hook; intentionally empty so the RTL stays zero-delay.
`define SD
`endif

package rs_bank_pkg;
    localparam int XLEN_DEF    = 64;
    localparam int TAG_W_DEF   = `PRN_BITS;
    localparam int ROB_W_DEF   = `ROB_BITS;
    localparam int FC_W_DEF    = 5;
    localparam int NCDB_DEF    = 3;
    localparam int ENTRIES_DEF = 8;
endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: holds two operands (value or pending tag),
// snoops all CDB channels for wakeup/bypass, and reports occupied/ready.
// Ports: alloc loads the dispatch fields, dealloc frees after issue, clear
// squashes; ready = occupied & both operands valid, from registered state.
module rs_entry
    import rs_bank_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int ROB_W = ROB_W_DEF,
    parameter int FC_W  = FC_W_DEF,
    parameter int NCDB  = NCDB_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  alloc,
    input  logic                  dealloc,
    input  logic [XLEN-1:0]       in_opa,
    input  logic                  in_opa_valid,
    input  logic [XLEN-1:0]       in_opb,
    input  logic                  in_opb_valid,
    input  logic [FC_W-1:0]       in_fc,
    input  logic [TAG_W-1:0]      in_prn,
    input  logic [ROB_W-1:0]      in_rob,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*TAG_W-1:0] cdb_tag,
    input  logic [NCDB*XLEN-1:0]  cdb_data,
    output logic                  occupied,
    output logic                  ready,
    output logic [XLEN-1:0]       opa,
    output logic [XLEN-1:0]       opb,
    output logic [FC_W-1:0]       fc,
    output logic [TAG_W-1:0]      prn,
    output logic [ROB_W-1:0]      rob
);

    logic             occ_q,   occ_d;
    logic             opa_v_q, opa_v_d;
    logic             opb_v_q, opb_v_d;
    logic [XLEN-1:0]  opa_q,   opa_d;
    logic [XLEN-1:0]  opb_q,   opb_d;
    logic [FC_W-1:0]  fc_q,    fc_d;
    logic [TAG_W-1:0] prn_q,   prn_d;
    logic [ROB_W-1:0] rob_q,   rob_d;

    logic [XLEN:0]    a_lk, b_lk;   // {hit, data}

    // Returns {hit, data}; scanning high-to-low lets the lowest channel win.
    function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] res;
        res = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, cdb_data[k*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    always_comb begin
        // During allocation the compare runs on the incoming tag (bypass),
        // otherwise on the stored one (wakeup).
        a_lk = cdb_lookup(alloc ? in_opa[TAG_W-1:0] : opa_q[TAG_W-1:0]);
        b_lk = cdb_lookup(alloc ? in_opb[TAG_W-1:0] : opb_q[TAG_W-1:0]);

        occ_d   = occ_q;
        opa_v_d = opa_v_q;
        opb_v_d = opb_v_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        fc_d    = fc_q;
        prn_d   = prn_q;
        rob_d   = rob_q;

        if (clear || dealloc) begin
            occ_d   = 1'b0;
            opa_v_d = 1'b0;
            opb_v_d = 1'b0;
            opa_d   = '0;
            opb_d   = '0;
            fc_d    = '0;
            prn_d   = '0;
            rob_d   = '0;
        end else if (alloc) begin
            occ_d   = 1'b1;
            opa_v_d = in_opa_valid | a_lk[XLEN];
            opb_v_d = in_opb_valid | b_lk[XLEN];
            opa_d   = (!in_opa_valid && a_lk[XLEN]) ? a_lk[XLEN-1:0] : in_opa;
            opb_d   = (!in_opb_valid && b_lk[XLEN]) ? b_lk[XLEN-1:0] : in_opb;
            fc_d    = in_fc;
            prn_d   = in_prn;
            rob_d   = in_rob;
        end else if (occ_q) begin
            if (!opa_v_q && a_lk[XLEN]) begin
                opa_d   = a_lk[XLEN-1:0];
                opa_v_d = 1'b1;
            end
            if (!opb_v_q && b_lk[XLEN]) begin
                opb_d   = b_lk[XLEN-1:0];
                opb_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q   <= `SD 1'b0;
            opa_v_q <= `SD 1'b0;
            opb_v_q <= `SD 1'b0;
            opa_q   <= `SD '0;
            opb_q   <= `SD '0;
            fc_q    <= `SD '0;
            prn_q   <= `SD '0;
            rob_q   <= `SD '0;
        end else begin
            occ_q   <= `SD occ_d;
            opa_v_q <= `SD opa_v_d;
            opb_v_q <= `SD opb_v_d;
            opa_q   <= `SD opa_d;
            opb_q   <= `SD opb_d;
            fc_q    <= `SD fc_d;
            prn_q   <= `SD prn_d;
            rob_q   <= `SD rob_d;
        end
    end

    assign occupied = occ_q;
    assign ready    = occ_q & opa_v_q & opb_v_q;
    assign opa      = opa_q;
    assign opb      = opb_q;
    assign fc       = fc_q;
    assign prn      = prn_q;
    assign rob      = rob_q;

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: ENTRIES rs_entry slots, lowest-free dispatch
// allocation and lowest-ready issue select, combinational issue outputs.
// Ports: dispatch (disp_*) with disp_ready, NCDB-channel CDB snoop (cdb_*),
// issue (iss_*) with iss_ready, flush, and free_count of unoccupied slots.
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int XLEN    = XLEN_DEF,
    parameter int TAG_W   = `PRN_BITS,
    parameter int ROB_W   = `ROB_BITS,
    parameter int FC_W    = FC_W_DEF,
    parameter int NCDB    = NCDB_DEF,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int CNT_W  = $clog2(ENTRIES) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  disp_valid,
    output logic                  disp_ready,
    input  logic [XLEN-1:0]       disp_opa,
    input  logic [XLEN-1:0]       disp_opb,
    input  logic                  disp_opa_valid,
    input  logic                  disp_opb_valid,
    input  logic [FC_W-1:0]       disp_fc,
    input  logic [TAG_W-1:0]      disp_prn,
    input  logic [ROB_W-1:0]      disp_rob,
    input  logic [NCDB-1:0]       cdb_valid,
    input  logic [NCDB*TAG_W-1:0] cdb_tag,
    input  logic [NCDB*XLEN-1:0]  cdb_data,
    output logic                  iss_valid,
    input  logic                  iss_ready,
    output logic [XLEN-1:0]       iss_opa,
    output logic [XLEN-1:0]       iss_opb,
    output logic [FC_W-1:0]       iss_fc,
    output logic [TAG_W-1:0]      iss_prn,
    output logic [ROB_W-1:0]      iss_rob,
    output logic [CNT_W-1:0]      free_count
);

    logic [ENTRIES-1:0] occ;
    logic [ENTRIES-1:0] rdy;
    logic [ENTRIES-1:0] alloc;
    logic [ENTRIES-1:0] dealloc;
    logic [XLEN-1:0]    e_opa [ENTRIES];
    logic [XLEN-1:0]    e_opb [ENTRIES];
    logic [FC_W-1:0]    e_fc  [ENTRIES];
    logic [TAG_W-1:0]   e_prn [ENTRIES];
    logic [ROB_W-1:0]   e_rob [ENTRIES];

    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   iss_idx;
    logic               disp_fire;
    logic               iss_fire;

    // Both encoders scan high-to-low so the last hit is the lowest index.
    always_comb begin
        free_idx = '0;
        iss_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!occ[i]) free_idx = IDX_W'(i);
            if (rdy[i])  iss_idx  = IDX_W'(i);
        end
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!occ[i]) free_count = free_count + CNT_W'(1);
        end
    end

    // disp_ready looks only at registered occupancy, so a slot freed by
    // issue this cycle cannot be refilled until the next one.
    assign disp_ready = ~&occ;
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign iss_valid  = (|rdy) & ~flush;
    assign iss_fire   = iss_valid & iss_ready;

    always_comb begin
        alloc   = '0;
        dealloc = '0;
        alloc[free_idx]  = disp_fire;
        dealloc[iss_idx] = iss_fire;
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        rs_entry #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .ROB_W (ROB_W),
            .FC_W  (FC_W),
            .NCDB  (NCDB)
        ) u_entry (
            .clock        (clock),
            .reset        (reset),
            .clear        (flush),
            .alloc        (alloc[g]),
            .dealloc      (dealloc[g]),
            .in_opa       (disp_opa),
            .in_opa_valid (disp_opa_valid),
            .in_opb       (disp_opb),
            .in_opb_valid (disp_opb_valid),
            .in_fc        (disp_fc),
            .in_prn       (disp_prn),
            .in_rob       (disp_rob),
            .cdb_valid    (cdb_valid),
            .cdb_tag      (cdb_tag),
            .cdb_data     (cdb_data),
            .occupied     (occ[g]),
            .ready        (rdy[g]),
            .opa          (e_opa[g]),
            .opb          (e_opb[g]),
            .fc           (e_fc[g]),
            .prn          (e_prn[g]),
            .rob          (e_rob[g])
        );
    end

    assign iss_opa = iss_valid ? e_opa[iss_idx] : '0;
    assign iss_opb = iss_valid ? e_opb[iss_idx] : '0;
    assign iss_fc  = iss_valid ? e_fc[iss_idx]  : '0;
    assign iss_prn = iss_valid ? e_prn[iss_idx] : '0;
    assign iss_rob = iss_valid ? e_rob[iss_idx] : '0;

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank with default parameters (8 entries, 64-bit
// operands, 6-bit tags, 5-bit ROB index, 3 CDB channels).
// Inputs change 1 time unit after the rising edge; checks follow a settle delay.
module tb_rs_bank;

    logic         clock;
    logic         reset;
    logic         flush;
    logic         disp_valid;
    logic         disp_ready;
    logic [63:0]  disp_opa;
    logic [63:0]  disp_opb;
    logic         disp_opa_valid;
    logic         disp_opb_valid;
    logic [4:0]   disp_fc;
    logic [5:0]   disp_prn;
    logic [4:0]   disp_rob;
    logic [2:0]   cdb_valid;
    logic [17:0]  cdb_tag;
    logic [191:0] cdb_data;
    logic         iss_valid;
    logic         iss_ready;
    logic [63:0]  iss_opa;
    logic [63:0]  iss_opb;
    logic [4:0]   iss_fc;
    logic [5:0]   iss_prn;
    logic [4:0]   iss_rob;
    logic [3:0]   free_count;

    int tests = 0;
    int fails = 0;

    rs_bank dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_opa       (disp_opa),
        .disp_opb       (disp_opb),
        .disp_opa_valid (disp_opa_valid),
        .disp_opb_valid (disp_opb_valid),
        .disp_fc        (disp_fc),
        .disp_prn       (disp_prn),
        .disp_rob       (disp_rob),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_opa        (iss_opa),
        .iss_opb        (iss_opb),
        .iss_fc         (iss_fc),
        .iss_prn        (iss_prn),
        .iss_rob        (iss_rob),
        .free_count     (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        disp_valid     = 1'b0;
        disp_opa       = '0;
        disp_opb       = '0;
        disp_opa_valid = 1'b0;
        disp_opb_valid = 1'b0;
        disp_fc        = '0;
        disp_prn       = '0;
        disp_rob       = '0;
        cdb_valid      = '0;
        cdb_tag        = '0;
        cdb_data       = '0;
    endtask

    // fc and prn are derived from rob so every op carries distinct metadata.
    task automatic drv_disp(input logic [63:0] a, input logic av,
                            input logic [63:0] b, input logic bv,
                            input logic [4:0] r);
        disp_valid     = 1'b1;
        disp_opa       = a;
        disp_opa_valid = av;
        disp_opb       = b;
        disp_opb_valid = bv;
        disp_rob       = r;
        disp_fc        = r;
        disp_prn       = {1'b0, r} + 6'd8;
    endtask

    task automatic set_cdb(input int ch, input logic [5:0] t, input logic [63:0] d);
        cdb_valid[ch]        = 1'b1;
        cdb_tag[ch*6 +: 6]   = t;
        cdb_data[ch*64 +: 64] = d;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        iss_ready = 1'b0;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_free_count", 64'(free_count), 64'd8);
        chk("rst_disp_ready", 64'(disp_ready), 64'd1);
        chk("rst_iss_valid",  64'(iss_valid),  64'd0);
        chk("rst_iss_opa",    iss_opa,         64'd0);

        // Wakeup through CDB1; CDB2 carries the same tag with other data.
        drv_disp(64'd5, 1'b1, 64'd12, 1'b0, 5'd7);
        step();
        idle();
        step();
        #1;
        chk("wake_c1_iss_valid", 64'(iss_valid), 64'd0);
        set_cdb(1, 6'd12, 64'h77);
        set_cdb(2, 6'd12, 64'h99);
        #1;
        chk("wake_c2_iss_valid", 64'(iss_valid), 64'd0);
        step();
        idle();
        #1;
        chk("wake_c3_iss_valid", 64'(iss_valid), 64'd1);
        chk("wake_c3_opa",       iss_opa,         64'd5);
        chk("wake_c3_opb",       iss_opb,         64'h77);
        chk("wake_c3_rob",       64'(iss_rob),    64'd7);
        chk("wake_c3_fc",        64'(iss_fc),     64'd7);
        chk("wake_c3_prn",       64'(iss_prn),    64'd15);
        chk("wake_c3_free",      64'(free_count), 64'd7);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        #1;
        chk("wake_after_free",  64'(free_count), 64'd8);
        chk("wake_after_valid", 64'(iss_valid),  64'd0);
        chk("wake_after_opb",   iss_opb,         64'd0);

        // Dispatch-cycle bypass from CDB0.
        drv_disp(64'd1, 1'b1, 64'd9, 1'b0, 5'd4);
        set_cdb(0, 6'd9, 64'hAA);
        #1;
        chk("byp_same_cycle_valid", 64'(iss_valid), 64'd0);
        step();
        idle();
        #1;
        chk("byp_next_valid", 64'(iss_valid), 64'd1);
        chk("byp_next_opb",   iss_opb,         64'hAA);
        chk("byp_next_opa",   iss_opa,         64'd1);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        #1;
        chk("byp_drain_free", 64'(free_count), 64'd8);

        // Fill all slots with ops waiting on tags 40..47.
        for (int i = 0; i < 8; i++) begin
            drv_disp(64'h100 + 64'(i), 1'b1, 64'd40 + 64'(i), 1'b0, 5'(i));
            step();
        end
        idle();
        #1;
        chk("full_free",       64'(free_count), 64'd0);
        chk("full_disp_ready", 64'(disp_ready), 64'd0);
        chk("full_iss_valid",  64'(iss_valid),  64'd0);
        drv_disp(64'h999, 1'b1, 64'h998, 1'b1, 5'd20);
        step();
        idle();
        #1;
        chk("ninth_free",      64'(free_count), 64'd0);
        chk("ninth_iss_valid", 64'(iss_valid),  64'd0);
        set_cdb(0, 6'd43, 64'h33);
        step();
        idle();
        #1;
        chk("full_wake_valid", 64'(iss_valid), 64'd1);
        chk("full_wake_opa",   iss_opa,         64'h103);
        chk("full_wake_opb",   iss_opb,         64'h33);
        chk("full_wake_rob",   64'(iss_rob),    64'd3);
        drv_disp(64'h500, 1'b1, 64'h501, 1'b1, 5'd21);
        iss_ready = 1'b1;
        #1;
        chk("iss_disp_ready_low", 64'(disp_ready), 64'd0);
        step();
        iss_ready = 1'b0;
        #1;
        chk("iss_disp_free",       64'(free_count), 64'd1);
        chk("iss_disp_ready_high", 64'(disp_ready), 64'd1);
        chk("iss_disp_refused",    64'(iss_valid),  64'd0);
        step();
        idle();
        #1;
        chk("refill_free",  64'(free_count), 64'd0);
        chk("refill_valid", 64'(iss_valid),  64'd1);
        chk("refill_opa",   iss_opa,         64'h500);
        chk("refill_rob",   64'(iss_rob),    64'd21);
        flush = 1'b1;
        #1;
        chk("flush_forces_idle", 64'(iss_valid), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_full_free", 64'(free_count), 64'd8);

        // Slots 2, 5, 6 ready; others wait on tag 50.
        for (int i = 0; i < 7; i++) begin
            if (i == 2 || i == 5 || i == 6)
                drv_disp(64'h10 + 64'(i), 1'b1, 64'h20 + 64'(i), 1'b1, 5'(i));
            else
                drv_disp(64'h10 + 64'(i), 1'b1, 64'd50, 1'b0, 5'(i));
            step();
        end
        idle();
        #1;
        chk("sel_free", 64'(free_count), 64'd1);
        for (int c = 0; c < 2; c++) begin
            chk("sel_hold_rob", 64'(iss_rob), 64'd2);
            chk("sel_hold_opa", iss_opa,       64'h12);
            step();
        end
        iss_ready = 1'b1;
        #1;
        chk("sel_order_0", 64'(iss_rob), 64'd2);
        step();
        chk("sel_order_1", 64'(iss_rob), 64'd5);
        step();
        chk("sel_order_2", 64'(iss_rob), 64'd6);
        step();
        iss_ready = 1'b0;
        #1;
        chk("sel_drained_valid", 64'(iss_valid),  64'd0);
        chk("sel_drained_free",  64'(free_count), 64'd4);

        // Wake the 4 remaining entries, then flush with dispatch and issue.
        set_cdb(0, 6'd50, 64'h50);
        step();
        idle();
        #1;
        chk("pre_flush_valid", 64'(iss_valid), 64'd1);
        chk("pre_flush_rob",   64'(iss_rob),   64'd0);
        chk("pre_flush_opb",   iss_opb,         64'h50);
        flush = 1'b1;
        iss_ready = 1'b1;
        drv_disp(64'hEE, 1'b1, 64'hEF, 1'b1, 5'd30);
        #1;
        chk("flush_cycle_valid", 64'(iss_valid), 64'd0);
        chk("flush_cycle_opa",   iss_opa,         64'd0);
        step();
        flush = 1'b0;
        iss_ready = 1'b0;
        idle();
        #1;
        chk("flush_free",  64'(free_count), 64'd8);
        chk("flush_valid", 64'(iss_valid),  64'd0);
        step();
        chk("flush_disp_absent", 64'(iss_valid), 64'd0);

        // Reset in the middle of operation.
        drv_disp(64'h42, 1'b1, 64'h43, 1'b1, 5'd9);
        step();
        idle();
        #1;
        chk("mid_rst_pre_valid", 64'(iss_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_free",  64'(free_count), 64'd8);
        chk("mid_rst_valid", 64'(iss_valid),  64'd0);
        chk("mid_rst_opa",   iss_opa,         64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rs_bank.md
RS_BANK -- requirements
Module: rs_bank

Interface
REQ-001 Parameter ENTRIES, default 8, number of reservation-station entries (power of two, >=2).
REQ-002 Parameter XLEN, default 64, operand data width.
REQ-003 Parameter TAG_W, default `PRN_BITS, physical-register tag width carried in an operand field while not valid.
REQ-004 Parameter ROB_W, default `ROB_BITS, ROB index width.
REQ-005 Parameter FC_W, default 5, function-code width.
REQ-006 Parameter NCDB, default 3, number of CDB broadcast channels.
REQ-007 Ports: clock in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-008 flush in 1, squash all entries; disp_valid in 1, dispatch request; disp_ready out 1, at least one free entry.
REQ-009 disp_opa/disp_opb in XLEN, value or tag (low TAG_W bits); disp_opa_valid/disp_opb_valid in 1, 1 = value, 0 = tag.
REQ-010 disp_fc in FC_W; disp_prn in TAG_W; disp_rob in ROB_W, carried unchanged to issue.
REQ-011 cdb_valid in NCDB; cdb_tag in NCDB*TAG_W; cdb_data in NCDB*XLEN; channel k occupies slice k.
REQ-012 iss_valid out 1; iss_ready in 1, FU accept; iss_opa/iss_opb out XLEN; iss_fc out FC_W; iss_prn out TAG_W; iss_rob out ROB_W.
REQ-013 free_count out $clog2(ENTRIES)+1, number of unoccupied entries.

Function
REQ-014 Dispatch fires when disp_valid & disp_ready & !flush; the entry written is the lowest-index free entry at the start of the cycle.
REQ-015 disp_ready is derived only from registered occupancy; an entry being issued this cycle is not reusable until the next cycle.
REQ-016 disp_valid with disp_ready=0 is ignored with no state change.
REQ-017 Dispatch bypass: a tag operand that matches a valid CDB tag in the dispatch cycle is captured as a value with valid=1.
REQ-018 Wakeup: each occupied entry compares every not-valid operand tag against all NCDB channels each cycle; on a match it latches the data and sets valid at the next edge.
REQ-019 If several channels match the same operand, the lowest channel index supplies the data.
REQ-020 An entry is ready when occupied & opa_valid & opb_valid, evaluated on registered state, so wakeup-to-issue latency is 1 cycle minimum.
REQ-021 Issue select picks the lowest-index ready entry; iss_valid=1 if any entry is ready.
REQ-022 Issue outputs are combinational from the selected entry; all issue data outputs are 0 when iss_valid=0.
REQ-023 Issue fires on iss_valid & iss_ready; the selected entry becomes free at that edge. If iss_ready=0, outputs hold, and the choice is re-evaluated next cycle.
REQ-024 Dispatch and issue in the same cycle are both honoured; free_count changes by +1, -1 or 0 accordingly.
REQ-025 flush frees all entries at the next edge, overrides dispatch, wakeup and issue in that cycle, and forces iss_valid=0 combinationally.
REQ-026 CDB inputs are ignored for free entries and for already-valid operands.

Reset
REQ-027 On reset all entries are freed and cleared to 0; disp_ready=1, free_count=ENTRIES, iss_valid=0, and all issue outputs are 0 after the edge.
REQ-028 Reset asserted mid-operation discards all in-flight entries, with the same priority as flush or higher.

Structure
REQ-029 XLEN/TAG_W/ROB_W/FC_W defaults and the `SD delay macro live in the shared project package/defines file.
REQ-030 One sub-module, rs_entry, holds a single entry: operand registers, wakeup compare across NCDB channels, and ready output. It is instantiated ENTRIES times.
REQ-031 Free-slot and ready-slot selection are lowest-index priority encoders implemented in rs_bank.

Verification
REQ-032 Reset, then idle: free_count=8, disp_ready=1, iss_valid=0, and iss_opa=0.
REQ-033 Dispatch opa=5 valid, opb=tag 12 invalid; CDB1 broadcasts tag 12, data 0x77 at cycle+2. Expected: iss_valid rises at cycle+3 with opa=5, opb=0x77.
REQ-034 Dispatch with opb tag 9 while CDB0 broadcasts tag 9, data 0xAA in the same cycle. Expected: the entry is ready next cycle with opb=0xAA.
REQ-035 Fill all 8 entries, then a 9th dispatch: disp_ready=0 and the 9th is ignored. Issue one entry with iss_ready=1 and dispatch in the same cycle: the new dispatch is refused; the next cycle it is accepted into the freed slot, and free_count returns to 0.
REQ-036 Three ready entries in slots 2, 5, 6, with iss_ready held 0 for 2 cycles: issue outputs stay on slot 2. Then iss_ready=1 for 3 cycles: the issue order is 2, 5, 6.
REQ-037 Flush with 4 entries occupied and a simultaneous dispatch: next cycle free_count=8, iss_valid=0, and the dispatched op is absent.
